// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the Y86-64 execute-stage controller: instruction codes,
// ALU opcodes, condition functions and the controller FSM states.
package exec_ctrl_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_IADDQ  = 4'hC;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // iaddq is only a real instruction when the optional extension is built in.
  function automatic logic icode_legal(input logic [3:0] icode, input logic iaddq_en);
    return (icode <= I_POPQ) || (iaddq_en && (icode == I_IADDQ));
  endfunction

  function automatic logic icode_sets_cc(input logic [3:0] icode, input logic iaddq_en);
    return (icode == I_OPQ) || (iaddq_en && (icode == I_IADDQ));
  endfunction

endpackage

// File: rtl/exec_ctrl_cond.sv
// Combinational evaluation of the Y86-64 condition functions used by cmovXX/jXX;
// bad_fn flags function codes with no defined condition.
module cond_eval
  import exec_ctrl_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd,
  output logic       bad_fn
);

  logic w_lt;

  assign w_lt = sf ^ of;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cnd    = 1'b0;
    bad_fn = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = w_lt | zf;
      C_L:      cnd = w_lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~w_lt;
      C_G:      cnd = ~w_lt & ~zf;
      default:  bad_fn = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// Y86-64 execute-stage controller: IDLE/ISSUE/HOLD handshake FSM driving an external ALU.
// Define EXEC_IADDQ_EN to decode icode 0xC as iaddq; otherwise 0xC is illegal.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic [1:0]   alu_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic         err,
  output logic         zf,
  output logic         sf,
  output logic         of
);

`ifdef EXEC_IADDQ_EN
  localparam logic IADDQ_EN = 1'b1;
`else
  localparam logic IADDQ_EN = 1'b0;
`endif

  localparam logic [W-1:0] STACK_STEP = W'(8);

  state_e       r_state;
  logic [3:0]   r_icode;
  logic [3:0]   r_ifun;
  logic [1:0]   r_alu_op;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [W-1:0] r_valE;
  logic         r_out_valid;
  logic         r_cnd;
  logic         r_err;
  logic         r_zf;
  logic         r_sf;
  logic         r_of;

  logic [1:0]   w_op;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_uses_cond;
  logic         w_cond_cnd;
  logic         w_bad_fn;
  logic         w_cnd;
  logic         w_err;
  logic         w_sets_cc;
  logic         w_sign_a;
  logic         w_sign_b;
  logic         w_sign_r;
  logic         w_of;

  // Operand selection from the decode-stage fields, consumed on the accept edge.
  always_comb begin
    w_op = ALU_ADD;
    w_a  = '0;
    w_b  = '0;
    case (icode)
      I_OPQ: begin
        w_op = ifun[1:0];
        w_a  = valB;
        w_b  = valA;
      end
      I_RRMOVQ: w_a = valA;
      I_IRMOVQ: w_b = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_a = valB;
        w_b = valC;
      end
      I_CALL, I_PUSHQ: begin
        w_op = ALU_SUB;
        w_a  = valB;
        w_b  = STACK_STEP;
      end
      I_RET, I_POPQ: begin
        w_a = valB;
        w_b = STACK_STEP;
      end
      I_IADDQ: begin
        if (IADDQ_EN) begin
          w_a = valB;
          w_b = valC;
        end
      end
      default: ;
    endcase
  end

  // Conditions read the flags as they stand before this instruction retires.
  cond_eval u_cond_eval (
    .ifun   (r_ifun),
    .zf     (r_zf),
    .sf     (r_sf),
    .of     (r_of),
    .cnd    (w_cond_cnd),
    .bad_fn (w_bad_fn)
  );

  assign w_uses_cond = (r_icode == I_RRMOVQ) || (r_icode == I_JXX);
  assign w_cnd       = w_uses_cond & w_cond_cnd;
  assign w_err       = ~icode_legal(r_icode, IADDQ_EN) | (w_uses_cond & w_bad_fn);
  assign w_sets_cc   = icode_sets_cc(r_icode, IADDQ_EN);

  assign w_sign_a = r_alu_a[W-1];
  assign w_sign_b = r_alu_b[W-1];
  assign w_sign_r = alu_res[W-1];

  always_comb begin
    w_of = 1'b0;
    case (r_alu_op)
      ALU_ADD: w_of = (w_sign_a == w_sign_b) && (w_sign_r != w_sign_a);
      ALU_SUB: w_of = (w_sign_a != w_sign_b) && (w_sign_r != w_sign_a);
      default: w_of = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: every register, datapath included, is reset because all of them are architecturally visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_icode     <= I_HALT;
      r_ifun      <= 4'h0;
      r_alu_op    <= ALU_ADD;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_valE      <= '0;
      r_out_valid <= 1'b0;
      r_cnd       <= 1'b0;
      r_err       <= 1'b0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_icode  <= icode;
            r_ifun   <= ifun;
            r_alu_op <= w_op;
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_valE      <= alu_res;
          r_cnd       <= w_cnd;
          r_err       <= w_err;
          r_out_valid <= 1'b1;
          if (w_sets_cc) begin
            r_zf <= (alu_res == '0);
            r_sf <= w_sign_r;
            r_of <= w_of;
          end
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating with rst keeps a handshake from appearing to complete while reset is held.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign out_valid = r_out_valid;
  assign valE      = r_valE;
  assign cnd       = r_cnd;
  assign err       = r_err;
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_of;

endmodule

// File: tb/tb_exec_ctrl.sv
// Scoreboard bench for exec_ctrl: directed scenarios plus random instructions checked
// against an arithmetic reference model of the execute stage.
module tb_exec_ctrl;

  localparam int W = 64;

`ifdef EXEC_IADDQ_EN
  localparam bit IADDQ = 1'b1;
`else
  localparam bit IADDQ = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] valE;
    logic         chk_valE;
    logic         cnd;
    logic         err;
    logic         zf;
    logic         sf;
    logic         of;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA, valB, valC;
  logic [1:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valE;
  logic         cnd, err, zf, sf, of;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           completions = 0;
  int           ready_mode = 0;
  logic         m_zf, m_sf, m_of;
  logic         prev_ov = 1'b0;
  logic [W-1:0] prev_valE;
  logic         prev_cnd, prev_err;
  logic [W-1:0] last_valE;
  logic         last_cnd, last_err;

  exec_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .out_valid(out_valid), .out_ready(out_ready), .valE(valE),
    .cnd(cnd), .err(err), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU sitting outside the controller.
  always_comb begin
    case (alu_op)
      2'b00:   alu_res = alu_a + alu_b;
      2'b01:   alu_res = alu_a - alu_b;
      2'b10:   alu_res = alu_a & alu_b;
      default: alu_res = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no DUT response within the cycle budget", what);
  endtask

  function automatic logic signed [W:0] sext(input logic [W-1:0] x);
    return $signed({x[W-1], x});
  endfunction

  // {bad_fn, cnd} from the Y86-64 condition table.
  function automatic logic [1:0] cond_ref(input logic [3:0] f, input logic z, s, o);
    case (f)
      4'd0:    return 2'b01;
      4'd1:    return {1'b0, (s != o) || z};
      4'd2:    return {1'b0, s != o};
      4'd3:    return {1'b0, z};
      4'd4:    return {1'b0, !z};
      4'd5:    return {1'b0, s == o};
      4'd6:    return {1'b0, (s == o) && !z};
      default: return 2'b10;
    endcase
  endfunction

  // Overflow = the exact signed result does not fit the wrapped W-bit result.
  function automatic exp_t ref_model(input logic [3:0] ic, fn, input logic [W-1:0] va, vb, vc,
                                     input logic z0, s0, o0);
    exp_t e;
    logic signed [W:0] ex;
    logic [1:0] cb;
    logic setcc;
    e.valE = '0; e.chk_valE = 1'b1; e.cnd = 1'b0; e.err = 1'b0;
    e.zf = z0; e.sf = s0; e.of = o0; e.acc_cyc = 0;
    setcc = 1'b0;
    ex = '0;
    case (ic)
      4'h2, 4'h7: begin
        e.valE = (ic == 4'h2) ? va : '0;
        cb = cond_ref(fn, z0, s0, o0);
        e.cnd = cb[0];
        e.err = cb[1];
      end
      4'h3: e.valE = vc;
      4'h4, 4'h5: e.valE = vb + vc;
      4'h6: begin
        setcc = 1'b1;
        case (fn[1:0])
          2'd0: begin e.valE = vb + va; ex = sext(vb) + sext(va); end
          2'd1: begin e.valE = vb - va; ex = sext(vb) - sext(va); end
          2'd2: begin e.valE = vb & va; ex = sext(e.valE); end
          default: begin e.valE = vb ^ va; ex = sext(e.valE); end
        endcase
      end
      4'h8, 4'hA: e.valE = vb - 64'd8;
      4'h9, 4'hB: e.valE = vb + 64'd8;
      4'h0, 4'h1: e.valE = '0;
      4'hC: begin
        if (IADDQ) begin
          setcc = 1'b1;
          e.valE = vb + vc;
          ex = sext(vb) + sext(vc);
        end else begin
          e.err = 1'b1;
          e.chk_valE = 1'b0;
        end
      end
      default: begin
        e.err = 1'b1;
        e.chk_valE = 1'b0;
      end
    endcase
    if (setcc) begin
      e.zf = (e.valE == '0);
      e.sf = e.valE[W-1];
      e.of = (ex != sext(e.valE));
    end
    return e;
  endfunction

  task automatic issue(input logic [3:0] ic, fn, input logic [W-1:0] va, vb, vc);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; icode = ic; ifun = fn; valA = va; valB = vb; valC = vc;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        timeout_fail("accept");
        in_valid = 1'b0;
        return;
      end
    end
    e = ref_model(ic, fn, va, vb, vc, m_zf, m_sf, m_of);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    m_zf = e.zf; m_sf = e.sf; m_of = e.of;
    @(posedge clk); #1;
    in_valid = 1'b0;
    icode = 4'($urandom); valA = {$urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout_fail("drain");
        return;
      end
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        timeout_fail("out_valid");
        return;
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 64'd1;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency, stability while held, and scoreboard compare at completion.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_while_out_valid", in_ready, 1'b0);
        if (prev_ov) begin
          check("hold_valE", valE, prev_valE);
          check("hold_cnd", cnd, prev_cnd);
          check("hold_err", err, prev_err);
        end else if (exp_q.size() == 0) begin
          timeout_fail("unexpected out_valid");
        end else begin
          check("latency", cyc - exp_q[0].acc_cyc, 2);
        end
        if (out_ready && exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.chk_valE) check("valE", valE, e.valE);
          check("cnd", cnd, e.cnd);
          check("err", err, e.err);
          check("zf", zf, e.zf);
          check("sf", sf, e.sf);
          check("of", of, e.of);
          completions++;
          last_valE = valE; last_cnd = cnd; last_err = err;
        end
      end
      prev_ov = out_valid; prev_valE = valE; prev_cnd = cnd; prev_err = err;
    end
  end

  initial begin
    int c0;
    rst = 1'b1; in_valid = 1'b0; icode = '0; ifun = '0;
    valA = '0; valB = '0; valC = '0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_valE", valE, '0);
    check("rst_cnd_err", {cnd, err}, 2'b00);
    check("rst_alu_op", alu_op, 2'b00);
    check("rst_alu_ab", alu_a | alu_b, '0);
    check("rst_cc", {zf, sf, of}, 3'b100);

    issue(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0);
    wait_drain();
    check("addq_valE", last_valE, 64'h8000_0000_0000_0000);
    check("addq_cc", {zf, sf, of}, 3'b011);

    issue(4'h6, 4'h1, 64'd5, 64'd5, '0);
    wait_drain();
    check("subq_valE", last_valE, '0);
    check("subq_zf", zf, 1'b1);
    issue(4'h7, 4'h3, '0, '0, 64'h40);
    wait_drain();
    check("je_cnd", last_cnd, 1'b1);
    check("je_cc", {zf, sf, of}, 3'b100);

    ready_mode = 2;
    c0 = completions;
    issue(4'hA, 4'h0, '0, 64'h100, '0);
    wait_out_valid();
    repeat (3) @(posedge clk);
    ready_mode = 0;
    wait_drain();
    repeat (3) @(negedge clk);
    check("push_valE", last_valE, 64'hF8);
    check("push_single", completions - c0, 1);

    issue(4'hC, 4'h0, '0, 64'd3, 64'd4);
    wait_drain();
    if (IADDQ) begin
      check("iaddq_valE", last_valE, 64'd7);
      check("iaddq_err", last_err, 1'b0);
      check("iaddq_cc", {zf, sf, of}, 3'b000);
    end else begin
      check("iaddq_err", last_err, 1'b1);
      check("iaddq_cc", {zf, sf, of}, 3'b100);
    end

    issue(4'h2, 4'h8, 64'h55, '0, '0);
    wait_drain();
    check("cmov8_err_cnd", {last_err, last_cnd}, 2'b10);

    ready_mode = 2;
    issue(4'h6, 4'h1, 64'd10, 64'd3, '0);
    wait_out_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    @(negedge clk);
    check("pre_rst_sf", sf, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("hold_rst_out_valid", out_valid, 1'b0);
    check("hold_rst_cc", {zf, sf, of}, 3'b100);
    #1 rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ic, fn;
      ic = 4'($urandom_range(0, 15));
      if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0) fn = 4'($urandom);
      else fn = 4'($urandom_range(0, 6));
      issue(ic, fn, rnd_val(), rnd_val(), rnd_val());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    ready_mode = 0;
    wait_drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
